// File: rtl/gate_tt_sequencer_if.sv
// Bundle between the truth-table sequencer and whatever drives and observes it.
// master: issues start/op_sel, returns the gate-under-test output, reads results.
// slave : the sequencer itself.
//   start     : begin a run (honoured in IDLE or DONE only)
//   op_sel    : expected function, 00=OR 01=AND 10=XOR 11=NOR
//   dut_out   : output of the gate under test
//   a_out/b_out : registered stimulus to the gate
//   busy/done/pass/err_count/err_vec : run status and results
interface gate_tt_sequencer_if;
   logic       start;
   logic [1:0] op_sel;
   logic       dut_out;
   logic       a_out;
   logic       b_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [3:0] err_vec;

   modport master (
      output start, op_sel, dut_out,
      input  a_out, b_out, busy, done, pass, err_count, err_vec
   );

   modport slave (
      input  start, op_sel, dut_out,
      output a_out, b_out, busy, done, pass, err_count, err_vec
   );
endinterface

// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer for a 2-input gate under test. Steps A/B through
// 00,01,10,11, holds each vector HOLD_CYCLES cycles, samples the gate output on
// the last edge of each hold window and accumulates a verdict.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   io    : gate_tt_sequencer_if.slave (start/op_sel/dut_out in, stimulus and results out)
//
// state | meaning
// IDLE  | waiting for start, outputs at reset values
// DRIVE | stepping through the four vectors, busy=1
// DONE  | results valid and held, a/b parked at 1/1, start restarts
module gate_tt_sequencer #(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   gate_tt_sequencer_if.slave    io
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [1:0]       vec_q, vec_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]       op_reg_q, op_reg_d;
   logic             a_q, a_d;
   logic             b_q, b_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [2:0]       err_count_q, err_count_d;
   logic [3:0]       err_vec_q, err_vec_d;
   logic             expected;

   always_comb begin
      case (op_reg_q)
         2'b00:   expected = vec_q[1] | vec_q[0];
         2'b01:   expected = vec_q[1] & vec_q[0];
         2'b10:   expected = vec_q[1] ^ vec_q[0];
         default: expected = ~(vec_q[1] | vec_q[0]);
      endcase
   end

   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      hold_cnt_d  = hold_cnt_q;
      op_reg_d    = op_reg_q;
      a_d         = a_q;
      b_d         = b_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      err_count_d = err_count_q;
      err_vec_d   = err_vec_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (io.start) begin
               op_reg_d    = io.op_sel;
               vec_d       = 2'd0;
               hold_cnt_d  = '0;
               a_d         = 1'b0;
               b_d         = 1'b0;
               err_count_d = 3'd0;
               err_vec_d   = 4'd0;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               busy_d      = 1'b1;
               state_d     = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (hold_cnt_q == HOLD_LAST) begin
               hold_cnt_d = '0;
               if (io.dut_out != expected) begin
                  err_count_d      = err_count_q + 3'd1;
                  err_vec_d[vec_q] = 1'b1;
               end
               if (vec_q == 2'd3) begin
                  // verdict uses the count including this final compare
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_count_d == 3'd0);
                  a_d     = 1'b1;
                  b_d     = 1'b1;
               end else begin
                  vec_d = vec_q + 2'd1;
                  a_d   = vec_d[1];
                  b_d   = vec_d[0];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         vec_q       <= 2'd0;
         hold_cnt_q  <= '0;
         op_reg_q    <= 2'b00;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_count_q <= 3'd0;
         err_vec_q   <= 4'd0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         hold_cnt_q  <= hold_cnt_d;
         op_reg_q    <= op_reg_d;
         a_q         <= a_d;
         b_q         <= b_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_count_q <= err_count_d;
         err_vec_q   <= err_vec_d;
      end
   end

   assign io.a_out     = a_q;
   assign io.b_out     = b_q;
   assign io.busy      = busy_q;
   assign io.done      = done_q;
   assign io.pass      = pass_q;
   assign io.err_count = err_count_q;
   assign io.err_vec   = err_vec_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: two instances (H=4 and H=1) each driving a
// behavioural gate; expected runs are queued when a start is accepted and a
// negedge monitor checks per-cycle stimulus, timing and the final verdict.
module tb_gate_tt_sequencer;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;

   // gate kinds: 0 OR, 1 AND, 2 XOR, 3 NOR, 4 stuck-0, 5 stuck-1
   int   kind [2];
   int   hv   [2];

   typedef struct {
      int       s;
      int       h;
      bit [2:0] cnt;
      bit [3:0] vec;
   } exp_t;

   exp_t exp_q [2][$];

   gate_tt_sequencer_if ifc0 ();
   gate_tt_sequencer_if ifc1 ();

   gate_tt_sequencer #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .io(ifc0.slave)
   );
   gate_tt_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .io(ifc1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) cyc <= cyc + 1;

   function automatic bit gate_fn(int k, bit a, bit b);
      case (k)
         0: return a | b;
         1: return a & b;
         2: return a ^ b;
         3: return !(a | b);
         4: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic bit ref_fn(int op, bit a, bit b);
      case (op)
         0: return a | b;
         1: return a & b;
         2: return a ^ b;
         default: return !(a | b);
      endcase
   endfunction

   always_comb ifc0.dut_out = gate_fn(kind[0], ifc0.a_out, ifc0.b_out);
   always_comb ifc1.dut_out = gate_fn(kind[1], ifc1.a_out, ifc1.b_out);

   logic       a_s [2], b_s [2], busy_s [2], done_s [2], pass_s [2];
   logic [2:0] cnt_s [2];
   logic [3:0] vec_s [2];
   assign a_s[0] = ifc0.a_out;      assign a_s[1] = ifc1.a_out;
   assign b_s[0] = ifc0.b_out;      assign b_s[1] = ifc1.b_out;
   assign busy_s[0] = ifc0.busy;    assign busy_s[1] = ifc1.busy;
   assign done_s[0] = ifc0.done;    assign done_s[1] = ifc1.done;
   assign pass_s[0] = ifc0.pass;    assign pass_s[1] = ifc1.pass;
   assign cnt_s[0] = ifc0.err_count; assign cnt_s[1] = ifc1.err_count;
   assign vec_s[0] = ifc0.err_vec;  assign vec_s[1] = ifc1.err_vec;

   function automatic void chk(string name, int d, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s dut%0d cyc=%0d actual=%0d required=%0d", name, d, cyc, act, req);
      end
   endfunction

   // Expected result of a run follows directly from the four vectors.
   function automatic void push_exp(int d, int op, int s);
      exp_t e;
      e.s = s; e.h = hv[d]; e.cnt = 0; e.vec = 0;
      for (int i = 0; i < 4; i++) begin
         bit a = (i >= 2);
         bit b = (i % 2) == 1;
         if (gate_fn(kind[d], a, b) != ref_fn(op, a, b)) begin
            e.cnt   = e.cnt + 1;
            e.vec[i] = 1'b1;
         end
      end
      exp_q[d].push_back(e);
   endfunction

   function automatic void mon(int d);
      exp_t e;
      int   rel;
      if (exp_q[d].size() == 0) return;
      e   = exp_q[d][0];
      rel = cyc - e.s;
      if (rel < 0) return;
      if (rel < 4 * e.h) begin
         chk("busy_in_run", d, int'(busy_s[d]), 1);
         chk("done_in_run", d, int'(done_s[d]), 0);
         chk("ab_vector", d, int'({a_s[d], b_s[d]}), rel / e.h);
      end else begin
         chk("done_end", d, int'(done_s[d]), 1);
         chk("busy_end", d, int'(busy_s[d]), 0);
         chk("err_count", d, int'(cnt_s[d]), int'(e.cnt));
         chk("err_vec", d, int'(vec_s[d]), int'(e.vec));
         chk("pass", d, int'(pass_s[d]), (e.cnt == 0) ? 1 : 0);
         chk("ab_parked", d, int'({a_s[d], b_s[d]}), 3);
         void'(exp_q[d].pop_front());
      end
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) mon(d);
      end
   end

   task automatic set_in(int d, bit st, int op);
      if (d == 0) begin ifc0.start = st; ifc0.op_sel = op[1:0]; end
      else        begin ifc1.start = st; ifc1.op_sel = op[1:0]; end
   endtask

   // Holds start for n edges; a start is accepted whenever no run is pending.
   task automatic hold_start(int d, int op, int n);
      bit accepted;
      accepted = 1'b0;
      @(negedge clk);
      set_in(d, 1'b1, op);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (exp_q[d].size() == 0) begin
            push_exp(d, op, cyc);
            accepted = 1'b1;
         end
      end
      @(negedge clk);
      set_in(d, 1'b0, op);
      if (n == 1 && accepted) begin
         chk("clear_done", d, int'(done_s[d]), 0);
         chk("clear_cnt", d, int'(cnt_s[d]), 0);
         chk("clear_vec", d, int'(vec_s[d]), 0);
         chk("clear_pass", d, int'(pass_s[d]), 0);
      end
   endtask

   task automatic wait_idle(int d);
      int n;
      n = 0;
      while (exp_q[d].size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q[d].size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout dut%0d pending=%0d required=0", d, exp_q[d].size());
         exp_q[d].delete();
      end
   endtask

   task automatic run(int d, int k, int op);
      kind[d] = k;
      hold_start(d, op, 1);
      wait_idle(d);
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      hv[0] = 4; hv[1] = 1;
      kind[0] = 0; kind[1] = 0;
      set_in(0, 1'b0, 0);
      set_in(1, 1'b0, 0);
      rst_n = 1'b0;
      #23;
      chk("rst_a", 0, int'(ifc0.a_out), 0);
      chk("rst_b", 0, int'(ifc0.b_out), 0);
      chk("rst_busy", 0, int'(ifc0.busy), 0);
      chk("rst_done", 0, int'(ifc0.done), 0);
      chk("rst_pass", 0, int'(ifc0.pass), 0);
      chk("rst_cnt", 0, int'(ifc0.err_count), 0);
      chk("rst_vec", 0, int'(ifc0.err_vec), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed runs: correct OR, AND vs OR, stuck-0 vs OR and NOR
      run(0, 0, 0);
      run(0, 0, 1);
      run(0, 4, 0);
      run(0, 4, 3);

      // start/op_sel activity during DRIVE is ignored
      kind[0] = 0;
      hold_start(0, 0, 1);
      repeat (5) @(negedge clk);
      hold_start(0, 3, 1);
      repeat (3) @(negedge clk);
      hold_start(0, 1, 2);
      wait_idle(0);
      // restart from DONE with a new op
      run(0, 0, 2);

      // reset while vector 2 is driven
      hold_start(0, 0, 1);
      repeat (9) @(negedge clk);
      #2;
      rst_n = 1'b0;
      exp_q[0].delete();
      exp_q[1].delete();
      #1;
      chk("mid_rst_a", 0, int'(ifc0.a_out), 0);
      chk("mid_rst_b", 0, int'(ifc0.b_out), 0);
      chk("mid_rst_busy", 0, int'(ifc0.busy), 0);
      chk("mid_rst_done", 0, int'(ifc0.done), 0);
      chk("mid_rst_cnt", 0, int'(ifc0.err_count), 0);
      chk("mid_rst_vec", 0, int'(ifc0.err_vec), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(0, 0, 0);

      // H=1 with a correct XOR gate
      run(1, 2, 2);

      // start held high through a whole run: second run begins in DONE
      kind[0] = 3;
      hold_start(0, 3, 4 * 4 + 3);
      wait_idle(0);
      kind[1] = 1;
      hold_start(1, 1, 4 * 1 + 3);
      wait_idle(1);

      // randomized runs on both instances
      for (int r = 0; r < 24; r++) begin
         int d;
         d = int'($urandom_range(0, 1));
         run(d, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
